// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_arbiter
// Function : Round-robin owner of one shared LED with dwell limit and off-gap.
// Revision : 1.0 - initial release
// ============================================================================
module led_arbiter #(
   parameter int DWELL     = 25_000_000,
   parameter int GAP       = 2_500_000,
   parameter int SLOW_HALF = 6_250_000,
   parameter int FAST_HALF = 1_562_500
) (
   input  logic       CLK25MHZ,
   input  logic       ck_rst,
   input  logic [3:0] req,
   input  logic [7:0] mode,
   output logic       led,
   output logic [3:0] grant,
   output logic       busy
);

   localparam int c_half_max = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int c_dw_w     = $clog2(DWELL + 1);
   localparam int c_gap_w    = $clog2(GAP + 1);
   localparam int c_bl_w     = $clog2(c_half_max + 1);

   localparam logic [c_dw_w-1:0]  c_dwell_last = c_dw_w'(DWELL - 1);
   localparam logic [c_gap_w-1:0] c_gap_last   = c_gap_w'(GAP - 1);
   localparam logic [c_bl_w-1:0]  c_slow_last  = c_bl_w'(SLOW_HALF - 1);
   localparam logic [c_bl_w-1:0]  c_fast_last  = c_bl_w'(FAST_HALF - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t              r_state;
   logic [1:0]          r_rr_ptr;
   logic [1:0]          r_owner;
   logic [1:0]          r_mode;
   logic [c_dw_w-1:0]   r_dwell_cnt;
   logic [c_bl_w-1:0]   r_blink_cnt;
   logic                r_phase;
   logic [c_gap_w-1:0]  r_gap_cnt;

   state_t              w_state_nxt;
   logic [1:0]          w_rr_nxt;
   logic [1:0]          w_owner_nxt;
   logic [1:0]          w_mode_nxt;
   logic [c_dw_w-1:0]   w_dwell_nxt;
   logic [c_bl_w-1:0]   w_blink_nxt;
   logic                w_phase_nxt;
   logic [c_gap_w-1:0]  w_gap_nxt;
   logic                w_led_nxt;
   logic [3:0]          w_grant_nxt;
   logic                w_busy_nxt;

   logic [3:0]          w_rot;
   logic [1:0]          w_offset;
   logic [1:0]          w_winner;
   logic [1:0]          w_sel_mode;
   logic                w_any;
   logic [c_bl_w-1:0]   w_half_last;

   // Requests rotated so that bit 0 is the requester at rr_ptr.
   always_comb begin
      w_rot = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         w_rot[i] = req[2'(r_rr_ptr + 2'(i))];
      end
      if (w_rot[0])      w_offset = 2'd0;
      else if (w_rot[1]) w_offset = 2'd1;
      else if (w_rot[2]) w_offset = 2'd2;
      else               w_offset = 2'd3;
   end

   assign w_any       = |req;
   assign w_winner    = r_rr_ptr + w_offset;
   assign w_sel_mode  = mode[{w_winner, 1'b0} +: 2];
   assign w_half_last = (r_mode == 2'd3) ? c_fast_last : c_slow_last;

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      w_mode_nxt  = r_mode;
      w_dwell_nxt = r_dwell_cnt;
      w_blink_nxt = r_blink_cnt;
      w_phase_nxt = r_phase;
      w_gap_nxt   = r_gap_cnt;

      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_GRANT;
               w_owner_nxt = w_winner;
               w_mode_nxt  = w_sel_mode;
               w_dwell_nxt = '0;
               w_blink_nxt = '0;
               w_phase_nxt = 1'b1;
            end
         end
         S_GRANT: begin
            if ((r_dwell_cnt == c_dwell_last) || !req[r_owner]) begin
               w_state_nxt = S_GAP;
               w_gap_nxt   = '0;
               w_rr_nxt    = r_owner + 2'd1;
            end else begin
               w_dwell_nxt = r_dwell_cnt + 1'b1;
               if (r_mode[1]) begin
                  if (r_blink_cnt == w_half_last) begin
                     w_blink_nxt = '0;
                     w_phase_nxt = ~r_phase;
                  end else begin
                     w_blink_nxt = r_blink_cnt + 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            // The end of the gap doubles as the IDLE arbitration cycle.
            if (r_gap_cnt == c_gap_last) begin
               if (w_any) begin
                  w_state_nxt = S_GRANT;
                  w_owner_nxt = w_winner;
                  w_mode_nxt  = w_sel_mode;
                  w_dwell_nxt = '0;
                  w_blink_nxt = '0;
                  w_phase_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_gap_nxt = r_gap_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_grant_nxt = (w_state_nxt == S_GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
      w_led_nxt   = (w_state_nxt == S_GRANT) &&
                    ((w_mode_nxt == 2'd1) || (w_mode_nxt[1] && w_phase_nxt));
   end

   always_ff @(posedge CLK25MHZ) begin
      if (!ck_rst) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= 2'd0;
         r_owner     <= 2'd0;
         r_mode      <= 2'd0;
         r_dwell_cnt <= '0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_gap_cnt   <= '0;
         led         <= 1'b0;
         grant       <= 4'b0000;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_owner     <= w_owner_nxt;
         r_mode      <= w_mode_nxt;
         r_dwell_cnt <= w_dwell_nxt;
         r_blink_cnt <= w_blink_nxt;
         r_phase     <= w_phase_nxt;
         r_gap_cnt   <= w_gap_nxt;
         led         <= w_led_nxt;
         grant       <= w_grant_nxt;
         busy        <= w_busy_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_arbiter
// Function : Directed and randomized checks of led_arbiter against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_arbiter;

   localparam int DWELL = 16;
   localparam int GAP   = 4;
   localparam int SLOW  = 4;
   localparam int FAST  = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [7:0] mode  = 8'h00;
   logic       led;
   logic [3:0] grant;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Model: m_st 0=idle 1=grant 2=gap; m_t counts cycles within the phase.
   int         m_st = 0;
   int         m_t = 0;
   int         m_owner = 0;
   int         m_ptr = 0;
   int         m_mode = 0;
   logic       m_led = 1'b0;
   logic [3:0] m_grant = 4'b0000;
   logic       m_busy = 1'b0;

   always #5 clk = ~clk;

   led_arbiter #(
      .DWELL(DWELL), .GAP(GAP), .SLOW_HALF(SLOW), .FAST_HALF(FAST)
   ) dut (
      .CLK25MHZ(clk), .ck_rst(rst_n), .req(req), .mode(mode),
      .led(led), .grant(grant), .busy(busy)
   );

   task automatic model_start(input logic [3:0] rq, input logic [7:0] md);
      bit found = 0;
      for (int i = 0; i < 4; i++) begin
         if (!found && rq[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            found = 1;
         end
      end
      m_mode = int'(md[2*m_owner +: 2]);
      m_st   = 1;
      m_t    = 0;
   endtask

   task automatic model_edge(input logic r, input logic [3:0] rq, input logic [7:0] md);
      if (!r) begin
         m_st = 0; m_t = 0; m_ptr = 0;
      end else begin
         case (m_st)
            0: if (rq != 0) model_start(rq, md);
            1: begin
               if (m_t == DWELL-1 || !rq[m_owner]) begin
                  m_st = 2; m_t = 0; m_ptr = (m_owner + 1) % 4;
               end else begin
                  m_t++;
               end
            end
            default: begin
               if (m_t == GAP-1) begin
                  if (rq != 0) model_start(rq, md);
                  else m_st = 0;
               end else begin
                  m_t++;
               end
            end
         endcase
      end
      m_busy  = (m_st != 0);
      m_grant = (m_st == 1) ? 4'(1 << m_owner) : 4'b0000;
      case (m_mode)
         1:       m_led = (m_st == 1);
         2:       m_led = (m_st == 1) && ((m_t / SLOW) % 2 == 0);
         3:       m_led = (m_st == 1) && ((m_t / FAST) % 2 == 0);
         default: m_led = 1'b0;
      endcase
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic [7:0] md);
      @(negedge clk);
      rst_n = r; req = rq; mode = md;
      model_edge(r, rq, md);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 4'b1111, 8'hFF);
         checks++;
         if (led !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got led=%b grant=%b busy=%b want 0 0000 0", led, grant, busy);
         end
      end
   endtask

   task automatic test_solid();
      step(1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < DWELL; k++) begin
         step(1'b1, 4'b0010, 8'h04);
         checks++;
         if (grant !== 4'b0010 || led !== 1'b1) begin
            errors++;
            $display("FAIL solid_grant k=%0d: got grant=%b led=%b want 0010 1", k, grant, led);
         end
      end
      for (int k = 0; k < GAP; k++) begin
         step(1'b1, 4'b0010, 8'h04);
         checks++;
         if (grant !== 4'b0000 || led !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL solid_gap k=%0d: got grant=%b led=%b busy=%b want 0000 0 1", k, grant, led, busy);
         end
      end
      step(1'b1, 4'b0010, 8'h04);
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL solid_regrant: got grant=%b want 0010", grant);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      step(1'b0, 4'b1111, 8'h55);
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'(1 << (g % 4));
         for (int k = 0; k < DWELL; k++) begin
            step(1'b1, 4'b1111, 8'h55);
            checks++;
            if (grant !== exp_g || led !== 1'b1) begin
               errors++;
               $display("FAIL rr_grant g=%0d k=%0d: got grant=%b led=%b want %b 1", g, k, grant, led, exp_g);
            end
         end
         if (g < 4) begin
            for (int k = 0; k < GAP; k++) begin
               step(1'b1, 4'b1111, 8'h55);
               checks++;
               if (grant !== 4'b0000 || led !== 1'b0) begin
                  errors++;
                  $display("FAIL rr_gap g=%0d k=%0d: got grant=%b led=%b want 0000 0", g, k, grant, led);
               end
            end
         end
      end
   endtask

   task automatic test_early_release();
      step(1'b0, 4'b0000, 8'h55);
      for (int k = 0; k <= 5; k++) begin
         step(1'b1, 4'b1100, 8'h55);
         checks++;
         if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL early_own k=%0d: got grant=%b want 0100", k, grant);
         end
      end
      step(1'b1, 4'b1000, 8'h55);
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL early_drop: got grant=%b busy=%b want 0000 1", grant, busy);
      end
      for (int k = 1; k < GAP; k++) step(1'b1, 4'b1000, 8'h55);
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL early_gap: got grant=%b want 0000", grant);
      end
      step(1'b1, 4'b1000, 8'h55);
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("FAIL early_next: got grant=%b want 1000", grant);
      end
   endtask

   task automatic test_fast_blink();
      logic exp_led;
      step(1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < DWELL; k++) begin
         step(1'b1, 4'b0001, (k < 6) ? 8'h03 : 8'h01);
         exp_led = ((k / 2) % 2 == 0);
         checks++;
         if (grant !== 4'b0001 || led !== exp_led) begin
            errors++;
            $display("FAIL fast k=%0d: got grant=%b led=%b want 0001 %b", k, grant, led, exp_led);
         end
      end
      step(1'b1, 4'b0001, 8'h01);
      checks++;
      if (grant !== 4'b0000 || led !== 1'b0) begin
         errors++;
         $display("FAIL fast_end: got grant=%b led=%b want 0000 0", grant, led);
      end
   endtask

   task automatic test_mid_reset();
      step(1'b0, 4'b0000, 8'h55);
      for (int k = 0; k <= 7; k++) step(1'b1, 4'b0001, 8'h55);
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_pre: got grant=%b want 0001", grant);
      end
      step(1'b0, 4'b0001, 8'h55);
      checks++;
      if (led !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_rst: got led=%b grant=%b busy=%b want 0 0000 0", led, grant, busy);
      end
      step(1'b1, 4'b0110, 8'h55);
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_after: got grant=%b want 0010", grant);
      end
   endtask

   task automatic test_random();
      logic [3:0] rq = 4'b0000;
      logic [7:0] md;
      logic       r;
      step(1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 5) == 0) rq = 4'($urandom);
         md = 8'($urandom);
         r  = ($urandom_range(0, 150) != 0);
         step(r, rq, md);
         checks++;
         if (grant !== m_grant || led !== m_led || busy !== m_busy) begin
            errors++;
            $display("FAIL random k=%0d: got grant=%b led=%b busy=%b want %b %b %b",
                     k, grant, led, busy, m_grant, m_led, m_busy);
         end
         checks++;
         if (!$onehot0(grant)) begin
            errors++;
            $display("FAIL onehot k=%0d: got grant=%b want one-hot or zero", k, grant);
         end
      end
   endtask

   initial begin
      test_reset();
      test_solid();
      test_round_robin();
      test_early_release();
      test_fast_blink();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001: The block SHALL have parameter DWELL, default 25_000_000, giving the maximum grant length in cycles (1 s at 25 MHz).
REQ-002: The block SHALL have parameter GAP, default 2_500_000, giving the forced LED-off cycles between grants.
REQ-003: The block SHALL have parameter SLOW_HALF, default 6_250_000, giving the slow-blink half-period in cycles.
REQ-004: The block SHALL have parameter FAST_HALF, default 1_562_500, giving the fast-blink half-period in cycles.
REQ-005: The block SHALL have port CLK25MHZ, input, 1 bit: the single clock, taken from the clock wizard output; all logic on its rising edge.
REQ-006: The block SHALL have port ck_rst, input, 1 bit: reset, synchronous, active-low.
REQ-007: The block SHALL have port req, input, 4 bits: per-requester LED request, level-sensitive.
REQ-008: The block SHALL have port mode, input, 8 bits: 2 bits per requester, where mode[2i+1:2i] is requester i's pattern (0 off, 1 solid, 2 slow blink, 3 fast blink).
REQ-009: The block SHALL have port led, output, 1 bit: the shared LED drive.
REQ-010: The block SHALL have port grant, output, 4 bits: the one-hot current owner, or 0000 when there is no owner.
REQ-011: The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012: led, grant and busy SHALL all be registered outputs.
REQ-013: The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-014: In IDLE with req==0000, the FSM SHALL stay in IDLE with led=0 and grant=0000.
REQ-015: In IDLE with any req bit set, the block SHALL select the first set bit at or after rr_ptr, searching ascending and wrapping 3->0.
REQ-016: On that selection, the block SHALL enter GRANT on the next edge, so grant is visible one cycle after req is sampled.
REQ-017: On GRANT entry, the block SHALL latch the winner's mode, clear dwell_cnt and the blink counter, and set blink phase=1.
REQ-018: In GRANT, led SHALL follow the latched mode: 0 gives led=0, 1 gives led=1, and 2/3 give led=phase.
REQ-019: In blink modes, phase SHALL toggle after every SLOW_HALF (mode 2) or FAST_HALF (mode 3) cycles, so the first led-high run is exactly HALF cycles.
REQ-020: Changes on mode during GRANT SHALL be ignored.
REQ-021: dwell_cnt SHALL increment every cycle in GRANT, and mode 0 SHALL still consume dwell.
REQ-022: GRANT SHALL exit to GAP when dwell_cnt==DWELL-1 (grant lasts exactly DWELL cycles) or when the owner's req bit is sampled low (early release).
REQ-023: On an early release, grant SHALL drop on the edge after req is sampled low.
REQ-024: On GRANT exit, rr_ptr SHALL be set to (owner+1) mod 4.
REQ-025: Requests from non-owners SHALL never preempt a grant.
REQ-026: In GAP, led SHALL be 0 and grant SHALL be 0000 for exactly GAP cycles, then the FSM SHALL return to IDLE.
REQ-027: Arbitration in IDLE SHALL occur in the same cycle as entry, so a pending request re-grants GAP+1 cycles after the previous grant ends.
REQ-028: A lone requester that holds req high SHALL be re-granted repeatedly, separated by gaps.
REQ-029: Each counter SHALL be $clog2(max+1) bits wide, and counters SHALL never wrap, because each is cleared on state entry.
REQ-030: If the owner drops req and its dwell expires in the same cycle, the FSM SHALL take a single transition to GAP.
REQ-031: If a requester drops req before the IDLE arbitration cycle, it SHALL not be granted.
REQ-032: grant SHALL be one-hot or zero at all times.

Reset
REQ-033: When ck_rst=0 at an edge, the block SHALL force state=IDLE, led=0, grant=0000, busy=0, rr_ptr=0 and all counters to 0, including when reset occurs mid-GRANT or mid-GAP.
REQ-034: After reset release, the first grant SHALL be decided with rr_ptr=0.

Verification (bench overrides DWELL=16, GAP=4, SLOW_HALF=4, FAST_HALF=2)
REQ-035: Reset case: hold ck_rst=0 for 2 cycles with req=1111 -> led=0, grant=0000, busy=0 throughout.
REQ-036: Solid case: req=0010 with mode[3:2]=1 held -> grant=0010 one cycle later and led=1 for 16 cycles, then led=0 and grant=0000 for 4 cycles, then grant=0010 again.
REQ-037: Round-robin case: req=1111 held from reset with all modes=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 16 cycles and separated by 4-cycle gaps.
REQ-038: Early-release case: owner 2 drops req[2] at dwell_cnt=5 while req=1100 -> grant=0000 on the next edge, then after 4 gap cycles grant=1000.
REQ-039: Fast-blink case: req=0001 with mode[1:0]=3 -> led=1,1,0,0 repeating for 16 cycles; changing mode mid-grant has no effect.
REQ-040: Mid-operation reset case: assert ck_rst=0 at dwell_cnt=7 -> led=0 and grant=0000 on the next edge; after release with req=0110, grant=0010 (rr_ptr restarted at 0).
